adder_arbiter: RTL

- Shares a single instance of the team's combinational `adder` (WIDTH-bit, a+b -> y) among NREQ requesters.
- Arbitration is round-robin; each requester uses a req/done handshake.
- Each accepted request goes through a fixed three-state sequence: operand capture, execution, and a registered result.
- Sits between the decode/control units and the shared adder in the deco datapath.

---
 rtl/adder_arbiter_if.sv | 33 +++
 rtl/adder_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/adder_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter_if
//  Purpose  : Requester-side bundle of the shared-adder arbiter: request lines,
//             packed operand buses, grants, completion pulses and the result.
//  Revision : 1.0  initial release
// ============================================================================
interface adder_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_bus;
  logic [NREQ*WIDTH-1:0] b_bus;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  carry;
  logic                  busy;

  // Requester side: drives requests and operands, observes the arbiter.
  modport master (
    output req, a_bus, b_bus,
    input  gnt, done, result, carry, busy
  );

  // Arbiter side.
  modport slave (
    input  req, a_bus, b_bus,
    output gnt, done, result, carry, busy
  );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder / adder_arbiter
//  Purpose  : Round-robin arbiter sharing one combinational WIDTH-bit adder
//             among NREQ requesters. Each accepted request runs a fixed
//             IDLE -> EXEC -> DONE sequence with a registered result.
//  Revision : 1.0  initial release
// ============================================================================

// Plain combinational adder shared by all requesters.
module adder #(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic      [WIDTH-1:0] y
);
  assign y = a + b;
endmodule

module adder_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  adder_arbiter_if.slave  bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q,  owner_d;
  logic [WIDTH-1:0] op_a_q,   op_a_d;
  logic [WIDTH-1:0] op_b_q,   op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;

  logic             win_valid;
  logic [IDW-1:0]   win_idx;
  logic [WIDTH-1:0] win_a, win_b;
  logic [WIDTH-1:0] sum;
  logic [NREQ-1:0]  owner_onehot;

  // The adder only ever sees the captured operands, so bus changes after
  // capture cannot disturb an operation in flight.
  adder #(.WIDTH(WIDTH)) u_adder (
    .a (op_a_q),
    .b (op_b_q),
    .y (sum)
  );

  // Circular search for the first requester at or above the rotating pointer.
  always_comb begin
    logic [IDW:0] cand;
    cand      = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!win_valid && bus.req[cand[IDW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // Select the winner's operand slices.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_a = bus.a_bus[i*WIDTH +: WIDTH];
        win_b = bus.b_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  // Next-state and next-datapath logic for the three-step sequence.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          owner_d = win_idx;
          op_a_d  = win_a;
          op_b_d  = win_b;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = sum;
        // An unsigned wrap leaves the sum below either operand.
        carry_d  = (sum < op_a_q);
        state_d  = S_DONE;
      end
      S_DONE: begin
        rr_ptr_d = (owner_q == IDW'(NREQ-1)) ? '0 : owner_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grant, completion pulse and busy decoded from state and owner.
  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) begin
        owner_onehot[i] = 1'b1;
      end
    end
    bus.gnt  = (state_q == S_EXEC || state_q == S_DONE) ? owner_onehot : '0;
    bus.done = (state_q == S_DONE) ? owner_onehot : '0;
    bus.busy = (state_q != S_IDLE);
  end

  assign bus.result = result_q;
  assign bus.carry  = carry_q;

endmodule
`default_nettype wire
